// File: rtl/simplerisc_pkg.sv
// Shared encodings for the simple RISC instruction sequencer:
// FSM state codes, opcode/sub constants, vsel encodings and the instruction layout.
package simplerisc_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] S_DECODE = 3'd1;
  localparam logic [STATE_W-1:0] S_WRIMM  = 3'd2;
  localparam logic [STATE_W-1:0] S_GETA   = 3'd3;
  localparam logic [STATE_W-1:0] S_GETB   = 3'd4;
  localparam logic [STATE_W-1:0] S_EXEC   = 3'd5;
  localparam logic [STATE_W-1:0] S_WRREG  = 3'd6;
  localparam logic [STATE_W-1:0] S_FIN    = 3'd7;

  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  localparam logic [1:0] SUB_MOV_IMM = 2'b10;
  localparam logic [1:0] SUB_MOV_REG = 2'b00;
  localparam logic [1:0] SUB_CMP     = 2'b01;
  localparam logic [1:0] SUB_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

  // imm8 overlaps {rd, sh, rm}
  typedef struct packed {
    logic [2:0] op;
    logic [1:0] sub;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
  } instr_t;

endpackage

// File: rtl/instr_sequencer_sx_ext.sv
// sx_ext: sign-extends an IW-bit value to OW bits.
module sx_ext #(
  parameter int unsigned IW = 8,
  parameter int unsigned OW = 16
) (
  input  logic [IW-1:0] din_i,
  output logic [OW-1:0] dout_o
);

  if (OW > IW) begin : g_ext
    assign dout_o = {{(OW-IW){din_i[IW-1]}}, din_i};
  end else begin : g_trunc
    assign dout_o = din_i[OW-1:0];
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer driving register-file and datapath controls.
// Optional CMP support is enabled with macro INSTR_SEQUENCER_CMP_EN.
module instr_sequencer
  import simplerisc_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  input  logic [15:0]   instr,
  output logic          instr_ready,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    vsel,
  output logic [1:0]    shift,
  output logic [1:0]    alu_op,
  output logic [DW-1:0] sximm,
  output logic          done,
  output logic          ill_err
);

`ifdef INSTR_SEQUENCER_CMP_EN
  localparam bit CmpEn = 1'b1;
`else
  localparam bit CmpEn = 1'b0;
`endif

  logic [STATE_W-1:0] state_q, state_d;
  instr_t             instr_q, instr_d;

  logic          ready_q, ready_d;
  logic [RW-1:0] readnum_q, readnum_d;
  logic [RW-1:0] writenum_q, writenum_d;
  logic          write_q, write_d;
  logic          loada_q, loada_d;
  logic          loadb_q, loadb_d;
  logic          loadc_q, loadc_d;
  logic          loads_q, loads_d;
  logic          asel_q, asel_d;
  logic [1:0]    vsel_q, vsel_d;
  logic [1:0]    shift_q, shift_d;
  logic [1:0]    alu_op_q, alu_op_d;
  logic          done_q, done_d;
  logic          ill_q, ill_d;

  logic is_mov_imm_c, is_mov_reg_c, is_alu_c, is_cmp_c;

  always_comb begin
    is_mov_imm_c = (instr_q.op == OP_MOV) && (instr_q.sub == SUB_MOV_IMM);
    is_mov_reg_c = (instr_q.op == OP_MOV) && (instr_q.sub == SUB_MOV_REG);
    is_cmp_c     = (instr_q.op == OP_ALU) && (instr_q.sub == SUB_CMP);
    is_alu_c     = (instr_q.op == OP_ALU) && (!is_cmp_c || CmpEn);
  end

  // Next state, plus the control outputs belonging to the state being entered
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    ready_d    = 1'b0;
    readnum_d  = '0;
    writenum_d = '0;
    write_d    = 1'b0;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    asel_d     = 1'b0;
    vsel_d     = VSEL_C;
    shift_d    = 2'b00;
    alu_op_d   = 2'b00;
    done_d     = 1'b0;
    ill_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (instr_valid && ready_q) begin
          instr_d = instr_t'(instr);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_mov_imm_c)      state_d = S_WRIMM;
        else if (is_mov_reg_c) state_d = S_GETB;
        else if (is_alu_c)     state_d = S_GETA;
        else begin
          state_d = S_FIN;
          ill_d   = 1'b1;
        end
      end
      S_WRIMM: state_d = S_FIN;
      S_GETA:  state_d = S_GETB;
      S_GETB:  state_d = S_EXEC;
      S_EXEC:  state_d = is_cmp_c ? S_FIN : S_WRREG;
      S_WRREG: state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_IDLE:  ready_d = 1'b1;
      S_WRIMM: begin
        writenum_d = RW'(instr_d.rn);
        vsel_d     = VSEL_IMM;
        write_d    = 1'b1;
      end
      S_GETA: begin
        readnum_d = RW'(instr_d.rn);
        loada_d   = 1'b1;
      end
      S_GETB: begin
        readnum_d = RW'(instr_d.rm);
        loadb_d   = 1'b1;
      end
      S_EXEC: begin
        shift_d  = instr_d.sh;
        loadc_d  = 1'b1;
        asel_d   = (instr_d.op == OP_MOV) || (instr_d.sub == SUB_MVN);
        alu_op_d = (instr_d.op == OP_ALU) ? instr_d.sub : 2'b00;
        loads_d  = CmpEn && (instr_d.op == OP_ALU) && (instr_d.sub == SUB_CMP);
      end
      S_WRREG: begin
        writenum_d = RW'(instr_d.rd);
        vsel_d     = VSEL_C;
        write_d    = 1'b1;
      end
      S_FIN:   done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      ready_q    <= 1'b0;
      readnum_q  <= '0;
      writenum_q <= '0;
      write_q    <= 1'b0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      asel_q     <= 1'b0;
      vsel_q     <= VSEL_C;
      shift_q    <= 2'b00;
      alu_op_q   <= 2'b00;
      done_q     <= 1'b0;
      ill_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      ready_q    <= ready_d;
      readnum_q  <= readnum_d;
      writenum_q <= writenum_d;
      write_q    <= write_d;
      loada_q    <= loada_d;
      loadb_q    <= loadb_d;
      loadc_q    <= loadc_d;
      loads_q    <= loads_d;
      asel_q     <= asel_d;
      vsel_q     <= vsel_d;
      shift_q    <= shift_d;
      alu_op_q   <= alu_op_d;
      done_q     <= done_d;
      ill_q      <= ill_d;
    end
  end

  sx_ext #(.IW(8), .OW(DW)) u_sx_ext (
    .din_i  ({instr_q.rd, instr_q.sh, instr_q.rm}),
    .dout_o (sximm)
  );

  assign instr_ready = ready_q;
  assign readnum     = readnum_q;
  assign writenum    = writenum_q;
  assign write       = write_q;
  assign loada       = loada_q;
  assign loadb       = loadb_q;
  assign loadc       = loadc_q;
  assign loads       = loads_q;
  assign asel        = asel_q;
  assign bsel        = 1'b0;
  assign vsel        = vsel_q;
  assign shift       = shift_q;
  assign alu_op      = alu_op_q;
  assign done        = done_q;
  assign ill_err     = ill_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: directed and random instructions checked cycle by cycle
// against a micro-step plan built from the instruction classes.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  vsel, shift, alu_op;
  logic [15:0] sximm;
  logic        done, ill_err;

  int errors = 0;
  int checks = 0;

  logic [21:0] plan[$];
  logic [21:0] obs;

  always #5 clk = ~clk;

  instr_sequencer #(.DW(16), .RW(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .readnum     (readnum),
    .writenum    (writenum),
    .write       (write),
    .loada       (loada),
    .loadb       (loadb),
    .loadc       (loadc),
    .loads       (loads),
    .asel        (asel),
    .bsel        (bsel),
    .vsel        (vsel),
    .shift       (shift),
    .alu_op      (alu_op),
    .sximm       (sximm),
    .done        (done),
    .ill_err     (ill_err)
  );

  assign obs = {instr_ready, readnum, writenum, write, loada, loadb, loadc, loads,
                asel, bsel, vsel, shift, alu_op, done, ill_err};

  function automatic logic [21:0] mk(input logic rdy, input logic [2:0] rn, input logic [2:0] wn,
                                     input logic wr, input logic la, input logic lb,
                                     input logic lc, input logic ls, input logic as_,
                                     input logic [1:0] vs, input logic [1:0] sh,
                                     input logic [1:0] aop, input logic dn, input logic il);
    return {rdy, rn, wn, wr, la, lb, lc, ls, as_, 1'b0, vs, sh, aop, dn, il};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected per-cycle outputs after the accept edge, one entry per cycle
  task automatic build_plan(input logic [15:0] ins);
    logic [2:0] op, rn, rd, rm;
    logic [1:0] sb, sh;
    bit cmp_en;
`ifdef INSTR_SEQUENCER_CMP_EN
    cmp_en = 1'b1;
`else
    cmp_en = 1'b0;
`endif
    op = ins[15:13]; sb = ins[12:11]; rn = ins[10:8];
    rd = ins[7:5];   sh = ins[4:3];   rm = ins[2:0];
    plan.delete();
    plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    if (op == 3'b110 && sb == 2'b10) begin
      plan.push_back(mk(0, 0, rn, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0, 0));
      plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0));
    end else if (op == 3'b110 && sb == 2'b00) begin
      plan.push_back(mk(0, rm, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
      plan.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, sh, 2'b00, 0, 0));
      plan.push_back(mk(0, 0, rd, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
      plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0));
    end else if (op == 3'b101 && (sb != 2'b01 || cmp_en)) begin
      plan.push_back(mk(0, rn, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
      plan.push_back(mk(0, rm, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
      plan.push_back(mk(0, 0, 0, 0, 0, 0, 1, sb == 2'b01, sb == 2'b11, 2'b00, sh, sb, 0, 0));
      if (sb != 2'b01)
        plan.push_back(mk(0, 0, rd, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
      plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0));
    end else begin
      plan.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 1));
    end
  endtask

  // Offer ins in IDLE, then follow it cycle by cycle until done; hold keeps valid high with junk
  task automatic issue(input logic [15:0] ins, input bit hold);
    logic [15:0] exp_sx;
    @(negedge clk);
    check("idle", 32'(obs), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0)));
    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clk);
    #1;
    instr = 16'($urandom);
    if (!hold) instr_valid = 1'b0;
    build_plan(ins);
    exp_sx = {{8{ins[7]}}, ins[7:0]};
    foreach (plan[k]) begin
      @(negedge clk);
      check($sformatf("i%04h_c%0d", ins, k + 1), 32'(obs), 32'(plan[k]));
      if (k == 0) check($sformatf("sximm_%04h", ins), 32'(sximm), 32'(exp_sx));
    end
  endtask

  initial begin
    logic [15:0] r;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset", 32'(obs), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0)));
    rst_n = 1'b1;

    issue(16'hD0F3, 1'b0);
    issue(16'hA140, 1'b1);
    issue(16'hA900, 1'b1);
    issue(16'hE000, 1'b0);
    issue(16'hC0B5, 1'b1);
    issue(16'hB26F, 1'b0);
    issue(16'hBB5A, 1'b1);
    issue(16'hD780, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r = 16'($urandom);
      case ($urandom_range(0, 3))
        0: r[15:13] = 3'b110;
        1: r[15:13] = 3'b101;
        default: ;
      endcase
      issue(r, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        instr_valid = 1'b0;
        check("gap", 32'(obs), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0)));
      end
    end

    // Abort an ADD in EXEC: no write may follow, and the sequencer idles cleanly
    @(negedge clk);
    check("pre_abort", 32'(obs), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0)));
    instr_valid = 1'b1;
    instr       = 16'hA140;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    build_plan(16'hA140);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("abort_c%0d", k + 1), 32'(obs), 32'(plan[k]));
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_rst1", 32'(obs), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0)));
    check("abort_sximm", 32'(sximm), 32'h0);
    @(negedge clk);
    check("abort_rst2", 32'(obs), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0)));
    rst_n = 1'b1;
    issue(16'hD27F, 1'b0);
    issue(16'hA900, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter DW, default 16: datapath and sign-extended immediate width (>=8).
REQ-002 SHALL have parameter RW, default 3: register-index width, driving an 8-entry register file.
REQ-003 SHALL have port clk, in, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, in, 1: synchronous, active-low reset.
REQ-005 SHALL have port instr_valid, in, 1: the instruction on instr is offered.
REQ-006 SHALL have port instr, in, 16: fields are op[15:13], sub[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
REQ-007 SHALL have port instr_ready, out, 1: the sequencer can accept an instruction.
REQ-008 SHALL have ports readnum/writenum, out, RW each, and write, out, 1: register-file control.
REQ-009 SHALL have ports loada, loadb, loadc, loads, asel, bsel, out, 1 each: datapath latch and operand-select controls.
REQ-010 SHALL have ports vsel, out, 2 (00=C, 10=sximm), shift, out, 2, alu_op, out, 2, and sximm, out, DW: datapath controls.
REQ-011 SHALL have ports done, out, 1, and ill_err, out, 1: single-cycle completion and illegal-instruction pulses.

Function
REQ-012 SHALL implement FSM states IDLE, DECODE, WRIMM, GETA, GETB, EXEC, WRREG and FIN.
REQ-013 SHALL assert instr_ready only in IDLE; instr_valid&&instr_ready SHALL latch instr and move to DECODE.
REQ-014 SHALL ignore instr changes after the latch; the latched copy SHALL drive every field output until FIN.
REQ-015 SHALL, in DECODE: op=110,sub=10 (MOV imm) go to WRIMM; op=110,sub=00 (MOV reg) go to GETB; op=101 (ALU) go to GETA; any other opcode go to FIN with ill_err=1.
REQ-016 SHALL, in WRIMM, drive writenum=Rn, vsel=10, write=1, then go to FIN.
REQ-017 SHALL, in GETA, drive readnum=Rn, loada=1, then go to GETB.
REQ-018 SHALL, in GETB, drive readnum=Rm, loadb=1, then go to EXEC.
REQ-019 SHALL, in EXEC, drive shift=sh and loadc=1; asel=1 for MOV reg and MVN, else 0; bsel=0; alu_op=sub for ALU and 00 for MOV reg; loads=1 only for CMP (101,01).
REQ-020 SHALL go from EXEC to FIN for CMP, and to WRREG otherwise.
REQ-021 SHALL, in WRREG, drive writenum=Rd, vsel=00, write=1, then go to FIN.
REQ-022 SHALL, in FIN, pulse done=1 for one cycle and return to IDLE; the next instruction is acceptable one cycle after FIN.
REQ-023 SHALL drive sximm = instr[7:0] sign-extended to DW, combinationally from the latched copy.
REQ-024 SHALL hold every strobe (write, load*, done, ill_err) at 0 in all states other than the one naming it.
REQ-025 SHALL give latency in cycles from the accept edge to done: MOV imm 3, MOV reg 5, ADD/AND/MVN 6, CMP 5, illegal 2.

Reset
REQ-026 SHALL, when rst_n=0 at a clock edge, enter IDLE and clear the latched instruction, in any state including mid-instruction.
REQ-027 SHALL, in reset, drive all strobes to 0, readnum/writenum/vsel/shift/alu_op to 0, and instr_ready to 0 while rst_n=0.
REQ-028 SHALL perform no register-file write during or because of an aborted instruction.

Configuration
REQ-029 SHALL, with macro INSTR_SEQUENCER_CMP_EN defined, execute CMP as in REQ-019/REQ-020.
REQ-030 SHALL, without INSTR_SEQUENCER_CMP_EN, treat 101,01 as illegal: DECODE goes to FIN with ill_err=1, and loads is tied to 0.

Structure
REQ-031 SHALL place the state enumeration, opcode/sub constants and vsel encodings in shared package simplerisc_pkg.
REQ-032 SHALL contain one sub-module, sx_ext, parameterised by width, performing the sign extension.

Verification
REQ-033 SHALL cover: MOV imm, instr=16'hD0F3 (Rn=0, imm=F3) -> write=1, writenum=0, sximm=16'hFFF3 in cycle 2, done in cycle 3.
REQ-034 SHALL cover: ADD R2=R1+R0, instr=16'hA140 -> readnum 1 then 0, loadc, write with writenum=2, done at cycle 6.
REQ-035 SHALL cover: CMP, instr=16'hA900 -> loads=1 in EXEC, no write, done at cycle 5; without the macro, ill_err and done at cycle 2.
REQ-036 SHALL cover: illegal opcode 16'hE000 -> ill_err and done together at cycle 2, no write, instr_ready back in cycle 3.
REQ-037 SHALL cover: rst_n=0 during EXEC of an ADD -> IDLE next cycle, no write, instr_ready=1 after release.
REQ-038 SHALL cover: instr_valid held high with instr changing mid-operation -> latched instruction executes, and the second is accepted only after FIN.
